uart_rx_frame_ctrl: RTL and testbench

//  Frame controller behind the UART receiver. Consumes the receiver's byte stream (RDATA/VALID)
//  and assembles frames: 0xA5 | CMD | LEN | LEN payload bytes | CHK.

---
 rtl/uart_rx_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles UART bytes into frames of the form
//   HEADER | CMD | LEN | LEN payload bytes | CHK
// The 8-bit wrapping sum covers CMD, LEN and the payload. A verified frame
// is held, with its payload readable through RD_ADDR/RD_DATA, until the
// host acknowledges it.
// Optional feature macro: UART_RX_TIMEOUT_EN. When it is defined, an
// inter-byte timeout aborts a frame that has stalled.
module uart_rx_frame_ctrl #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          TIMEOUT_CYC = 100_000,
    localparam int         AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    rdata_i,
    input  logic          valid_i,
    output logic          pkt_ready_o,
    output logic [7:0]    pkt_cmd_o,
    output logic [7:0]    pkt_len_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    input  logic          pkt_ack_i,
    output logic          err_cksum_o,
    output logic          err_len_o,
    output logic          err_drop_o,
    output logic          err_timeout_o,
    output logic          busy_o
);

    // Catch out-of-range configurations at elaboration time.
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("MAX_LEN must be within 1..255");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK, S_HOLD
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] idx_q, idx_d;
    logic       mem_we;
    logic       e_cksum_d, e_len_d, e_drop_d;
    logic       e_cksum_q, e_len_q, e_drop_q;
    logic [7:0] rd_data_q;
    logic       tmo_hit;

    logic [7:0] mem_q [MAX_LEN];

`ifdef UART_RX_TIMEOUT_EN
    logic [31:0] tmr_q;
    logic        e_tmo_q;
    logic        tmr_run;

    // Only the states in the middle of a frame are timed.
    assign tmr_run = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_DATA) || (state_q == S_CHK);
    // An arriving byte takes priority over a timeout in the same cycle.
    assign tmo_hit = tmr_run && !valid_i && (tmr_q == 32'(TIMEOUT_CYC - 1));

    // Inter-byte timer: cleared by every byte and idle outside the frame body.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q <= '0;
        end else if (valid_i || !tmr_run || tmo_hit) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + 32'd1;
        end
    end

    // Timeout pulse register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) e_tmo_q <= 1'b0;
        else         e_tmo_q <= tmo_hit;
    end

    assign err_timeout_o = e_tmo_q;
`else
    assign tmo_hit       = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    // Next state: frame parsing driven by accepted bytes, plus host release.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        e_cksum_d = 1'b0;
        e_len_d   = 1'b0;
        e_drop_d  = 1'b0;

        if (state_q == S_HOLD && pkt_ack_i) state_d = S_IDLE;

        if (valid_i) begin
            unique case (state_q)
                S_IDLE: if (rdata_i == HEADER) state_d = S_CMD;
                S_CMD: begin
                    cmd_d   = rdata_i;
                    sum_d   = rdata_i;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    len_d = rdata_i;
                    sum_d = sum_q + rdata_i;
                    idx_d = 8'd0;
                    if (rdata_i > 8'(MAX_LEN)) begin
                        e_len_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (rdata_i == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + rdata_i;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (rdata_i == sum_q) begin
                        state_d = S_HOLD;
                    end else begin
                        e_cksum_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                // The held frame is write-protected; the byte is lost.
                S_HOLD: e_drop_d = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    // Control and frame-header registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            e_cksum_q <= 1'b0;
            e_len_q   <= 1'b0;
            e_drop_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            e_cksum_q <= e_cksum_d;
            e_len_q   <= e_len_d;
            e_drop_q  <= e_drop_d;
        end
    end

    // Payload buffer write; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx_q[AW-1:0]] <= rdata_i;
    end

    // Registered payload read, active in every state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                      rd_data_q <= '0;
        else if (32'(rd_addr_i) < MAX_LEN) rd_data_q <= mem_q[rd_addr_i];
        else                              rd_data_q <= '0;
    end

    assign pkt_ready_o = (state_q == S_HOLD);
    assign busy_o      = (state_q != S_IDLE);
    assign pkt_cmd_o   = cmd_q;
    assign pkt_len_o   = len_q;
    assign rd_data_o   = rd_data_q;
    assign err_cksum_o = e_cksum_q;
    assign err_len_o   = e_len_q;
    assign err_drop_o  = e_drop_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with hand-computed expectations.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int AW      = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rdata = '0;
    logic          valid = 1'b0;
    logic          pkt_ready;
    logic [7:0]    pkt_cmd, pkt_len, rd_data;
    logic [AW-1:0] rd_addr = '0;
    logic          pkt_ack = 1'b0;
    logic          err_cksum, err_len, err_drop, err_timeout, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_cksum = 0, cnt_len = 0, cnt_drop = 0, cnt_tmo = 0;

    uart_rx_frame_ctrl #(
        .MAX_LEN(MAX_LEN), .HEADER(8'hA5), .TIMEOUT_CYC(50)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdata_i(rdata), .valid_i(valid),
        .pkt_ready_o(pkt_ready), .pkt_cmd_o(pkt_cmd), .pkt_len_o(pkt_len),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .pkt_ack_i(pkt_ack),
        .err_cksum_o(err_cksum), .err_len_o(err_len), .err_drop_o(err_drop),
        .err_timeout_o(err_timeout), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Count error pulses; each is one cycle wide so it is seen once.
    always @(negedge clk) begin
        if (err_cksum)   cnt_cksum++;
        if (err_len)     cnt_len++;
        if (err_drop)    cnt_drop++;
        if (err_timeout) cnt_tmo++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte per call; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rdata = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        rd_addr = a;
        @(posedge clk);
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic ack();
        @(negedge clk);
        pkt_ack = 1'b1;
        @(posedge clk);
        #1;
        pkt_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", pkt_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd", pkt_cmd, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_errs", {err_cksum, err_len, err_drop, err_timeout}, 0);
        rst_n = 1'b1;

        // Good 3-byte frame; sum 10+03+11+22+33 = 79.
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79});
        chk("t1_ready", pkt_ready, 1);
        chk("t1_cmd", pkt_cmd, 8'h10);
        chk("t1_len", pkt_len, 8'h03);
        rd(0, 8'h11, "t1_rd0");
        rd(1, 8'h22, "t1_rd1");
        rd(2, 8'h33, "t1_rd2");
        ack();
        chk("t1_ack_ready", pkt_ready, 0);
        chk("t1_ack_busy", busy, 0);

        // Bad checksum, then a good frame.
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h7A});
        chk("t2_err_cksum", err_cksum, 1);
        chk("t2_ready", pkt_ready, 0);
        chk("t2_busy", busy, 0);
        @(posedge clk); #1;
        chk("t2_pulse_width", err_cksum, 0);
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79});
        chk("t2_recover", pkt_ready, 1);
        ack();

        // Leading junk, zero-length frame.
        send_seq('{8'h00, 8'hFF});
        chk("t3_junk_busy", busy, 0);
        send_seq('{8'hA5, 8'h20, 8'h00, 8'h20});
        chk("t3_ready", pkt_ready, 1);
        chk("t3_len", pkt_len, 0);
        chk("t3_cmd", pkt_cmd, 8'h20);
        ack();

        // Header value inside payload, checksum wrap:
        // F0+02=F2, +A5=197->97, +A5=13C->3C.
        send_seq('{8'hA5, 8'hF0, 8'h02, 8'hA5, 8'hA5, 8'h3C});
        chk("t3b_ready", pkt_ready, 1);
        rd(1, 8'hA5, "t3b_rd1");
        ack();

        // LEN > MAX_LEN.
        send_seq('{8'hA5, 8'h01, 8'h11});
        chk("t4_err_len", err_len, 1);
        chk("t4_busy", busy, 0);
        send_seq('{8'h22, 8'h33});
        chk("t4_ignored", busy, 0);
        // Next frame 02 01 07, sum 0A; kept held for the drop test.
        send_seq('{8'hA5, 8'h02, 8'h01, 8'h07, 8'h0A});
        chk("t4_ready", pkt_ready, 1);

        // Bytes while held are dropped.
        send(8'h55);
        chk("t5_err_drop", err_drop, 1);
        send(8'h66);
        chk("t5_ready", pkt_ready, 1);
        chk("t5_cmd", pkt_cmd, 8'h02);
        chk("t5_len", pkt_len, 8'h01);
        rd(0, 8'h07, "t5_rd0");
        // ACK and byte together: release plus drop.
        @(negedge clk);
        rdata = 8'h77; valid = 1'b1; pkt_ack = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; pkt_ack = 1'b0;
        chk("t5_ack_ready", pkt_ready, 0);
        chk("t5_ack_drop", err_drop, 1);

        // Stalled frame.
        send_seq('{8'hA5, 8'h10});
`ifdef UART_RX_TIMEOUT_EN
        begin
            int k = 0;
            while (!err_timeout && k < 80) begin
                @(posedge clk); #1;
                k++;
            end
            chk("t6_err_timeout", err_timeout, 1);
            chk("t6_busy", busy, 0);
        end
        @(negedge clk);
        chk("t6_tmo_count", cnt_tmo, 1);
`else
        repeat (60) @(posedge clk);
        #1;
        chk("t6_still_busy", busy, 1);
        chk("t6_no_tmo", err_timeout, 0);
        // 10+01+44 = 55.
        send_seq('{8'h01, 8'h44, 8'h55});
        chk("t6_late_ready", pkt_ready, 1);
        rd(0, 8'h44, "t6_rd0");
        ack();
        @(negedge clk);
        chk("t6_tmo_count", cnt_tmo, 0);
`endif

        chk("cnt_cksum", cnt_cksum, 1);
        chk("cnt_len", cnt_len, 1);
        chk("cnt_drop", cnt_drop, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
